// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bpu_pkg
// Purpose  : Shared types for the branch target buffer. Holds the 2-bit
//            direction-counter encoding, the allocation state for new
//            entries and a reference layout of one BTB entry.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package bpu_pkg;

  // Direction counter. Bit 1 is the predicted direction, so the two
  // "taken" states share dir[1] = 1.
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } dir_t;

  // A freshly allocated entry has just been seen taken once.
  localparam dir_t DIR_ALLOC = WEAK_T;

  // Layout of one entry at the default geometry. The BTB itself uses a
  // parameter-sized copy of this layout and keeps the valid bits in a
  // separate vector so only they need the asynchronous reset.
  localparam int BTB_DEF_WIDTH    = 32;
  localparam int BTB_DEF_TAG_BITS = 8;

  typedef struct packed {
    logic                        valid;
    logic [BTB_DEF_TAG_BITS-1:0] tag;
    logic [BTB_DEF_WIDTH-1:0]    target;
    logic                        jump;
    dir_t                        dir;
  } btb_entry_t;

  function automatic logic dir_predicts_taken(input dir_t d);
    return d[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bpu_btb_if.sv
`default_nettype none
// ============================================================================
// Module   : bpu_btb_if
// Purpose  : Bundle between the pipeline and the branch target buffer.
// Ports    : master - pipeline side: drives PCF and the Execute resolution
//                     fields, receives prediction, flush and counters.
//            slave  - BTB side (opposite directions).
// Revision : 1.0  initial release
// ============================================================================
interface bpu_btb_if #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 32
) ();

  // Fetch lookup
  logic [WIDTH-1:0]    PCF;
  logic                PredTakenF;
  logic [WIDTH-1:0]    PredTargetF;

  // Execute resolution / training
  logic                UpdValidE;
  logic                IsJumpE;
  logic                TakenE;
  logic [WIDTH-1:0]    PCE;
  logic [WIDTH-1:0]    TargetE;
  logic                PredTakenE;
  logic [WIDTH-1:0]    PredTargetE;

  // Mispredict recovery
  logic                FlushBranch;
  logic [WIDTH-1:0]    RedirectPC;

  // Performance counters
  logic [CNT_BITS-1:0] BranchCount;
  logic [CNT_BITS-1:0] MispredCount;

  modport master (
    output PCF, UpdValidE, IsJumpE, TakenE, PCE, TargetE, PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, FlushBranch, RedirectPC, BranchCount, MispredCount
  );

  modport slave (
    input  PCF, UpdValidE, IsJumpE, TakenE, PCE, TargetE, PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, FlushBranch, RedirectPC, BranchCount, MispredCount
  );

endinterface
`default_nettype wire

// File: rtl/sat_counter2.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter2
// Purpose  : Next state of a 2-bit saturating direction counter.
// Ports    : i_dir   - current counter state
//            i_taken - resolved direction
//            o_dir   - next counter state (saturates at both ends)
// Revision : 1.0  initial release
// ============================================================================
module sat_counter2
  import bpu_pkg::*;
(
  input  dir_t i_dir,
  input  logic i_taken,
  output dir_t o_dir
);

  always_comb begin
    o_dir = i_dir;
    case (i_dir)
      STRONG_NT: o_dir = i_taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   o_dir = i_taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    o_dir = i_taken ? STRONG_T : WEAK_NT;
      STRONG_T:  o_dir = i_taken ? STRONG_T : WEAK_T;
      default:   o_dir = i_dir;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bpu_btb.sv
`default_nettype none
// ============================================================================
// Module   : bpu_btb
// Purpose  : Direct-mapped branch target buffer with per-entry 2-bit
//            direction counters. Looked up combinationally on PCF, trained
//            from Execute, detects mispredictions and supplies the flush and
//            corrected fetch PC. Counts resolved branches and mispredicts.
// Ports    : clk - clock, all state on the rising edge
//            rst - asynchronous active-low reset
//            bus - bpu_btb_if.slave (PCF / Pred*F lookup, *E training,
//                  FlushBranch / RedirectPC, BranchCount / MispredCount)
// Revision : 1.0  initial release
// ============================================================================
module bpu_btb
  import bpu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 8,
  parameter int CNT_BITS = 32
) (
  input  logic     clk,
  input  logic     rst,
  bpu_btb_if.slave bus
);

  localparam int IDX_BITS = $clog2(ENTRIES);

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [WIDTH-1:0]    target;
    logic                jump;
    dir_t                dir;
  } entry_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ENTRIES-1:0]  valid_q, valid_d;
  entry_t              entry_q [ENTRIES];
  logic [CNT_BITS-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_BITS-1:0] mispred_cnt_q, mispred_cnt_d;

  // --------------------------------------------------------------------------
  // Index / tag extraction. PC[1:0] and the bits above the tag do not take
  // part in the lookup.
  // --------------------------------------------------------------------------
  logic [IDX_BITS-1:0] f_idx, e_idx;
  logic [TAG_BITS-1:0] f_tag, e_tag;
  logic                unused_pc;

  assign f_idx = bus.PCF[IDX_BITS+1:2];
  assign f_tag = bus.PCF[TAG_BITS+IDX_BITS+1:IDX_BITS+2];
  assign e_idx = bus.PCE[IDX_BITS+1:2];
  assign e_tag = bus.PCE[TAG_BITS+IDX_BITS+1:IDX_BITS+2];
  assign unused_pc = ^{bus.PCF, bus.PCE};

  // --------------------------------------------------------------------------
  // Fetch lookup: reads the current flops, so a same-cycle update to the
  // same index is not visible until the next cycle.
  // --------------------------------------------------------------------------
  entry_t f_entry;
  logic   f_hit;
  logic   pred_taken;

  assign f_entry    = entry_q[f_idx];
  assign f_hit      = valid_q[f_idx] && (f_entry.tag == f_tag);
  assign pred_taken = f_hit && (f_entry.jump || dir_predicts_taken(f_entry.dir));

  assign bus.PredTakenF  = pred_taken;
  assign bus.PredTargetF = pred_taken ? f_entry.target : '0;

  // --------------------------------------------------------------------------
  // Mispredict detection
  // --------------------------------------------------------------------------
  logic             mispred;
  logic [WIDTH-1:0] redirect_pc;

  always_comb begin
    mispred     = 1'b0;
    redirect_pc = '0;
    if (bus.UpdValidE) begin
      if (bus.TakenE != bus.PredTakenE) begin
        mispred = 1'b1;
      end else if (bus.TakenE && (bus.TargetE != bus.PredTargetE)) begin
        mispred = 1'b1;
      end
    end
    if (mispred) begin
      redirect_pc = bus.TakenE ? bus.TargetE : bus.PCE + WIDTH'(4);
    end
  end

  assign bus.FlushBranch = mispred;
  assign bus.RedirectPC  = redirect_pc;

  // --------------------------------------------------------------------------
  // Training
  // --------------------------------------------------------------------------
  entry_t e_entry;
  logic   e_hit;
  dir_t   e_dir_next;
  logic   wr_en;
  entry_t wr_entry;

  assign e_entry = entry_q[e_idx];
  assign e_hit   = valid_q[e_idx] && (e_entry.tag == e_tag);

  sat_counter2 u_dir_next (
    .i_dir   (e_entry.dir),
    .i_taken (bus.TakenE),
    .o_dir   (e_dir_next)
  );

  always_comb begin
    valid_d  = valid_q;
    wr_en    = 1'b0;
    wr_entry = e_entry;
    if (bus.UpdValidE) begin
      if (e_hit) begin
        wr_en          = 1'b1;
        wr_entry.dir   = e_dir_next;
        wr_entry.jump  = bus.IsJumpE;
        if (bus.TakenE) begin
          wr_entry.target = bus.TargetE;
        end
      end else if (bus.TakenE) begin
        // Miss on a taken branch: allocate, evicting whatever aliased here.
        wr_en           = 1'b1;
        valid_d[e_idx]  = 1'b1;
        wr_entry.tag    = e_tag;
        wr_entry.target = bus.TargetE;
        wr_entry.jump   = bus.IsJumpE;
        wr_entry.dir    = DIR_ALLOC;
      end
    end
  end

  // Payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entry_q[e_idx] <= wr_entry;
    end
  end

  // --------------------------------------------------------------------------
  // Counters (wrap naturally)
  // --------------------------------------------------------------------------
  assign branch_cnt_d  = branch_cnt_q  + CNT_BITS'(bus.UpdValidE);
  assign mispred_cnt_d = mispred_cnt_q + CNT_BITS'(mispred);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q       <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.BranchCount  = branch_cnt_q;
  assign bus.MispredCount = mispred_cnt_q;

endmodule
`default_nettype wire
